// File: rtl/flexbus_pkg.sv
// rtl/flexbus_pkg.sv - shared FlexBus master constants, request type and wait clamp helper
package flexbus_pkg;

  // Bus cycle phases of the master FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  // FB_RW encoding
  localparam logic FB_RW_READ  = 1'b1;
  localparam logic FB_RW_WRITE = 1'b0;

  // Shortest legal data phases; a read needs one extra cycle for the slave's output register
  localparam logic [3:0] RD_WAIT_MIN = 4'd2;
  localparam logic [3:0] WR_WAIT_MIN = 4'd1;

  // Request captured at the handshake and held for the whole bus cycle
  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } fb_req_t;

  // Raise an out-of-range data-phase length to its minimum
  function automatic logic [3:0] clamp_wait(input logic [3:0] val, input logic [3:0] min_val);
    return (val < min_val) ? min_val : val;
  endfunction

endpackage

// File: rtl/flexbus_wait_cnt.sv
// rtl/flexbus_wait_cnt.sv - 4-bit loadable down-counter with zero flag for the data phase
module flexbus_wait_cnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Load takes priority; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/flexbus_master.sv
// rtl/flexbus_master.sv - FlexBus initiator turning single-beat requests into muxed bus cycles
module flexbus_master
  import flexbus_pkg::*;
#(
  parameter logic [3:0] RD_WAIT = 4'd2,
  parameter logic [3:0] WR_WAIT = 4'd1
) (
  input  logic        FB_CLK,
  input  logic        RST_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [31:0] rsp_rdata,
  output logic        FB_ALE,
  output logic        FB_CS,
  output logic        FB_RW,
  inout  wire  [31:0] FB_AD
);

  localparam logic [3:0] RD_N = clamp_wait(RD_WAIT, RD_WAIT_MIN);
  localparam logic [3:0] WR_N = clamp_wait(WR_WAIT, WR_WAIT_MIN);

  logic [1:0]  state_q,     state_d;
  fb_req_t     req_q,       req_d;
  logic        ale_q,       ale_d;
  logic        cs_q,        cs_d;
  logic        rw_q,        rw_d;
  logic        ad_oe_q,     ad_oe_d;
  logic [31:0] ad_out_q,    ad_out_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_rw_q,    rsp_rw_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        handshake;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic [3:0]  cnt_load_val;

  // Only an idle master out of reset can take a request
  assign req_ready = (state_q == ST_IDLE) && RST_n;
  assign handshake = req_valid && req_ready;

  // Counter holds remaining data cycles minus one, so zero marks the last one
  assign cnt_load_val = (req_q.rw == FB_RW_READ) ? (RD_N - 4'd1) : (WR_N - 4'd1);

  flexbus_wait_cnt u_wait_cnt (
    .clk_i      (FB_CLK),
    .rst_ni     (RST_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state and next-output logic; every bus pin comes straight from a register
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ale_d       = ale_q;
    cs_d        = cs_q;
    rw_d        = rw_q;
    ad_oe_d     = ad_oe_q;
    ad_out_d    = ad_out_q;
    rsp_valid_d = 1'b0;
    rsp_rw_d    = rsp_rw_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ale_d   = 1'b0;
        cs_d    = 1'b1;
        rw_d    = FB_RW_READ;
        ad_oe_d = 1'b0;
        if (handshake) begin
          state_d  = ST_ADDR;
          req_d    = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
          ale_d    = 1'b1;
          rw_d     = req_rw;
          ad_out_d = req_addr;
          ad_oe_d  = 1'b1;
        end
      end

      ST_ADDR: begin
        state_d  = ST_DATA;
        ale_d    = 1'b0;
        cs_d     = 1'b0;
        ad_out_d = req_q.wdata;
        // Reads release the bus for the whole data phase so the slave can drive it
        ad_oe_d  = (req_q.rw == FB_RW_WRITE);
        cnt_load = 1'b1;
      end

      ST_DATA: begin
        if (cnt_zero) begin
          state_d     = ST_TURN;
          cs_d        = 1'b1;
          ad_oe_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rw_d    = req_q.rw;
          // Only the last data cycle is trusted; the slave output register needs a cycle to fill
          if (req_q.rw == FB_RW_READ) begin
            rsp_rdata_d = FB_AD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_TURN: begin
        state_d = ST_IDLE;
        ale_d   = 1'b0;
        cs_d    = 1'b1;
        rw_d    = FB_RW_READ;
        ad_oe_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any cycle and releases the bus
  always_ff @(posedge FB_CLK) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ale_q       <= 1'b0;
      cs_q        <= 1'b1;
      rw_q        <= FB_RW_READ;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rw_q    <= FB_RW_READ;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ale_q       <= ale_d;
      cs_q        <= cs_d;
      rw_q        <= rw_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign FB_ALE    = ale_q;
  assign FB_CS     = cs_q;
  assign FB_RW     = rw_q;
  assign FB_AD     = ad_oe_q ? ad_out_q : 32'bz;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rw    = rsp_rw_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_flexbus_master.sv
// tb/tb_flexbus_master.sv - self-checking bench for flexbus_master with register responder
module tb_flexbus_master;

  localparam int LAT_RD = 4;
  localparam int LAT_WR = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid_b, req_valid_c;
  logic        req_rw;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, rsp_valid, rsp_rw, fb_ale, fb_cs, fb_rw;
  logic [31:0] rsp_rdata;
  wire  [31:0] fb_ad;

  logic        req_ready_b, rsp_valid_b, rsp_rw_b, fb_ale_b, fb_cs_b, fb_rw_b;
  logic [31:0] rsp_rdata_b;
  wire  [31:0] fb_ad_b;

  logic        req_ready_c, rsp_valid_c, rsp_rw_c, fb_ale_c, fb_cs_c, fb_rw_c;
  logic [31:0] rsp_rdata_c;
  wire  [31:0] fb_ad_c;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol_ale = 0, viol_drv = 0, viol_x = 0;

  logic [31:0] resp_mem [5];
  logic [31:0] model_mem [5];
  logic [31:0] lat_addr;
  logic [31:0] rd_out;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  flexbus_master dut (
    .FB_CLK(clk), .RST_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_rdata(rsp_rdata),
    .FB_ALE(fb_ale), .FB_CS(fb_cs), .FB_RW(fb_rw), .FB_AD(fb_ad)
  );

  flexbus_master #(.RD_WAIT(4'd4), .WR_WAIT(4'd3)) dut_b (
    .FB_CLK(clk), .RST_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rw(rsp_rw_b), .rsp_rdata(rsp_rdata_b),
    .FB_ALE(fb_ale_b), .FB_CS(fb_cs_b), .FB_RW(fb_rw_b), .FB_AD(fb_ad_b)
  );

  flexbus_master #(.RD_WAIT(4'd1), .WR_WAIT(4'd1)) dut_c (
    .FB_CLK(clk), .RST_n(rst_n), .req_valid(req_valid_c), .req_ready(req_ready_c),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_c), .rsp_rw(rsp_rw_c), .rsp_rdata(rsp_rdata_c),
    .FB_ALE(fb_ale_c), .FB_CS(fb_cs_c), .FB_RW(fb_rw_c), .FB_AD(fb_ad_c)
  );

  function automatic int map_idx(input logic [31:0] a);
    if (a[31:28] == 4'h6 && a[27:5] == 23'd0 && a[1:0] == 2'd0 && a[4:2] < 3'd5)
      return int'(a[4:2]);
    return -1;
  endfunction

  // Responder: drives registered read data while CS is low with RW = 1
  assign fb_ad = (!fb_cs && fb_rw) ? rd_out : 32'bz;

  always @(posedge clk) begin
    int ridx;
    cyc <= cyc + 1;
    ridx = map_idx(lat_addr);
    if (fb_ale) lat_addr <= fb_ad;
    if (!fb_cs && fb_rw) rd_out <= (ridx >= 0) ? resp_mem[ridx] : 32'hDEAD_0000;
    else rd_out <= 32'h5A5A_0F0F;
    if (!fb_cs && !fb_rw && ridx >= 0) resp_mem[ridx] <= fb_ad;
  end

  // Protocol monitors on the primary bus
  always @(negedge clk) begin
    if (fb_ale && !fb_cs) viol_ale++;
    if (!fb_cs && fb_rw && fb_ad !== rd_out) viol_drv++;
    if ((fb_ale || !fb_cs) && $isunknown(fb_ad)) viol_x++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the primary master with full per-cycle checking
  task automatic do_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    int n;
    int idx;
    n = rw ? (LAT_RD - 2) : (LAT_WR - 2);
    idx = map_idx(addr);
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 32) begin @(negedge clk); guard++; end
    check("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_rw = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    check("addr_ctl", {29'd0, fb_ale, fb_cs, fb_rw}, {29'd0, 1'b1, 1'b1, rw});
    check("addr_val", fb_ad, addr);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      check("data_ctl", {28'd0, fb_ale, fb_cs, fb_rw, rsp_valid}, {28'd0, 1'b0, 1'b0, rw, 1'b0});
      if (!rw) check("data_wval", fb_ad, wdata);
    end
    @(negedge clk);
    check("turn_ctl", {28'd0, fb_ale, fb_cs, rsp_valid, rsp_rw}, {28'd0, 1'b0, 1'b1, 1'b1, rw});
    if (rw) last_rd = (idx >= 0) ? model_mem[idx] : 32'hDEAD_0000;
    else if (idx >= 0) model_mem[idx] = wdata;
    check("rsp_rdata", rsp_rdata, last_rd);
    @(negedge clk);
    check("rsp_pulse", {30'd0, rsp_valid, fb_cs}, {30'd0, 1'b0, 1'b1});
  endtask

  // Handshake-to-rsp_valid latency on one of the alternate builds
  task automatic measure(input int which, input logic rw, output int lat);
    int guard;
    @(negedge clk);
    req_rw = rw; req_addr = 32'h6000_000C; req_wdata = $urandom;
    if (which == 1) req_valid_b = 1'b1; else req_valid_c = 1'b1;
    guard = 0;
    while (((which == 1) ? !req_ready_b : !req_ready_c) && guard < 32) begin
      @(negedge clk); guard++;
    end
    @(posedge clk);
    #1;
    req_valid_b = 1'b0; req_valid_c = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((which == 1) ? rsp_valid_b : rsp_valid_c) begin lat = k; break; end
    end
  endtask

  initial begin
    int hs [3];
    int lat;
    int guard;
    int seen;
    logic [31:0] bw [3];
    logic [31:0] ra;

    for (int i = 0; i < 5; i++) begin resp_mem[i] = 32'd0; model_mem[i] = 32'd0; end
    rd_out = 32'h5A5A_0F0F; lat_addr = 32'd0; last_rd = 32'd0;
    rst_n = 1'b0; req_valid = 1'b1; req_valid_b = 1'b0; req_valid_c = 1'b0;
    req_rw = 1'b0; req_addr = 32'h6000_0000; req_wdata = 32'hFFFF_FFFF;

    // Reset state, with a request pending that must not be taken
    repeat (3) @(negedge clk);
    check("rst_ctl", {29'd0, fb_ale, fb_cs, fb_rw}, {29'd0, 1'b0, 1'b1, 1'b1});
    check("rst_rsp", {30'd0, rsp_valid, rsp_rw}, {30'd0, 1'b0, 1'b1});
    check("rst_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    check("idle_ale", {31'd0, fb_ale}, 32'd0);

    // Test 1 and 2: directed write then read-back
    do_txn(1'b0, 32'h6000_0004, 32'h0000_1234);
    check("t1_mem", resp_mem[1], 32'h0000_1234);
    do_txn(1'b1, 32'h6000_0004, 32'd0);
    check("t2_rdata", rsp_rdata, 32'h0000_1234);

    // Test 3: back-to-back writes with req_valid held
    bw[0] = 32'hA5A5_0000; bw[1] = 32'hA5A5_0008; bw[2] = 32'hA5A5_0010;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_rw = 1'b0;
      req_addr = 32'h6000_0000 + 32'(i * 8); req_wdata = bw[i];
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      hs[i] = cyc;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    model_mem[0] = bw[0]; model_mem[2] = bw[1]; model_mem[4] = bw[2];
    repeat (6) @(negedge clk);
    check("b2b_gap1", 32'(hs[1] - hs[0]), 32'd4);
    check("b2b_gap2", 32'(hs[2] - hs[1]), 32'd4);
    check("b2b_mem0", resp_mem[0], bw[0]);
    check("b2b_mem2", resp_mem[2], bw[1]);
    check("b2b_mem4", resp_mem[4], bw[2]);

    // Test 4: random traffic against the model
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) ra = $urandom;
      else ra = 32'h6000_0000 | (32'($urandom_range(0, 4)) << 2);
      do_txn(1'($urandom_range(0, 1)), ra, $urandom);
    end

    // Test 5: reset during the second data cycle of a read
    do_txn(1'b0, 32'h6000_0008, 32'h0BAD_F00D);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h6000_0008;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1;
    seen = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    if (rsp_valid) seen++;
    rst_n = 1'b0;
    @(negedge clk);
    if (rsp_valid) seen++;
    check("rstmid_ctl", {29'd0, fb_ale, fb_cs, fb_rw}, {29'd0, 1'b0, 1'b1, 1'b1});
    check("rstmid_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    if (rsp_valid) seen++;
    check("rstmid_hold", {31'd0, fb_ale}, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    check("rstmid_norsp", 32'(seen), 32'd0);
    last_rd = 32'd0;
    do_txn(1'b1, 32'h6000_0008, 32'd0);
    check("rstmid_read", rsp_rdata, 32'h0BAD_F00D);

    // Test 6: alternate builds
    measure(1, 1'b1, lat);
    check("b_rd_lat", 32'(lat), 32'd6);
    measure(1, 1'b0, lat);
    check("b_wr_lat", 32'(lat), 32'd5);
    measure(2, 1'b1, lat);
    check("c_rd_lat", 32'(lat), 32'd4);
    measure(2, 1'b0, lat);
    check("c_wr_lat", 32'(lat), 32'd3);

    // Whole-run protocol and storage consistency
    check("viol_ale_cs", 32'(viol_ale), 32'd0);
    check("viol_drive", 32'(viol_drv), 32'd0);
    check("viol_x", 32'(viol_x), 32'd0);
    for (int i = 0; i < 5; i++) check("final_mem", resp_mem[i], model_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
